// File: rtl/misr_pkg.sv
// Shared definitions for the MISR response checker.
//   - default widths, feedback polynomial and seed
//   - FSM state enumeration
//   - misr_next(): one MISR compaction step
package misr_pkg;

  localparam int RESP_W_DEF = 26;
  localparam int SIG_W_DEF  = 32;
  localparam int CNT_W_DEF  = 16;

  localparam logic [SIG_W_DEF-1:0] POLY_DEF = 32'h04C11DB7;
  localparam logic [SIG_W_DEF-1:0] SEED_DEF = 32'h00000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Shift left by one, fold the shifted-out MSB back through the
  // polynomial taps, then XOR in the zero-extended response word.
  function automatic logic [SIG_W_DEF-1:0] misr_next(
    input logic [SIG_W_DEF-1:0]  sig,
    input logic [RESP_W_DEF-1:0] data,
    input logic [SIG_W_DEF-1:0]  poly
  );
    logic [SIG_W_DEF-1:0] fb;
    fb = sig[SIG_W_DEF-1] ? poly : {SIG_W_DEF{1'b0}};
    return {sig[SIG_W_DEF-2:0], 1'b0} ^ fb ^ SIG_W_DEF'(data);
  endfunction

endpackage

// File: rtl/misr_response_checker_if.sv
// Response stream between the circuit-under-test and the checker.
//   resp_valid : CUT presents a response word
//   resp_data  : response word, bit0=N388 ... bit25=N880
//   resp_ready : checker accepts the word this cycle
// master = CUT side, slave = checker side.
interface misr_response_checker_if #(
  parameter int RESP_W = misr_pkg::RESP_W_DEF
);
  logic              resp_valid;
  logic [RESP_W-1:0] resp_data;
  logic              resp_ready;

  modport master (output resp_valid, output resp_data, input resp_ready);
  modport slave  (input resp_valid, input resp_data, output resp_ready);
endinterface

// File: rtl/misr_reg.sv
// Signature register for the response checker.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, reloads SEED
//   load : reload SEED (campaign start)
//   en   : compact one response word
//   data : response word
//   sig  : current signature
module misr_reg
  import misr_pkg::*;
#(
  parameter logic [SIG_W_DEF-1:0] POLY = POLY_DEF,
  parameter logic [SIG_W_DEF-1:0] SEED = SEED_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  en,
  input  logic [RESP_W_DEF-1:0] data,
  output logic [SIG_W_DEF-1:0]  sig
);

  logic [SIG_W_DEF-1:0] sig_r;

  // Signature state: seed on reset/load, one compaction step per enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_r <= SEED;
    end else if (load) begin
      sig_r <= SEED;
    end else if (en) begin
      sig_r <= misr_next(sig_r, data, POLY);
    end else begin
      sig_r <= sig_r;
    end
  end

  assign sig = sig_r;

endmodule

// File: rtl/misr_response_checker.sv
// MISR response checker placed after the c880 circuit-under-test.
// Compacts a campaign of responses into a signature, counts accepted
// responses and compares the final signature against a golden value.
//   clk, rst       : clock, synchronous active-high reset
//   resp           : response stream (slave side; ready is driven here)
//   start          : begin a campaign (only honoured in IDLE or DONE)
//   abort          : return to IDLE from any state, signature untouched
//   num_patterns   : campaign length, sampled on start
//   golden_sig     : expected signature, sampled on start
//   busy           : campaign running (RUN or CHECK)
//   done           : verdict available
//   pass           : signature matched golden (valid while done)
//   signature      : current MISR value
//   pattern_count  : responses accepted in this campaign
module misr_response_checker
  import misr_pkg::*;
#(
  parameter int                   CNT_W = CNT_W_DEF,
  parameter logic [SIG_W_DEF-1:0] POLY  = POLY_DEF,
  parameter logic [SIG_W_DEF-1:0] SEED  = SEED_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  misr_response_checker_if.slave     resp,
  input  logic                       start,
  input  logic                       abort,
  input  logic [CNT_W-1:0]           num_patterns,
  input  logic [SIG_W_DEF-1:0]       golden_sig,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [SIG_W_DEF-1:0]       signature,
  output logic [CNT_W-1:0]           pattern_count
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_r;
  logic [CNT_W-1:0]       count_r;
  logic [CNT_W-1:0]       target_r;
  logic [SIG_W_DEF-1:0]   golden_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   pass_r;

  logic                   accept_start_s;
  logic                   transfer_s;
  logic [SIG_W_DEF-1:0]   sig_s;
  logic [CNT_W-1:0]       count_inc_s;

  // abort masks both start and a same-cycle transfer so the signature
  // register never moves on an aborted cycle.
  assign accept_start_s = start & ~abort &
                          ((state_r == ST_IDLE) | (state_r == ST_DONE));
  assign transfer_s     = (state_r == ST_RUN) & resp.resp_valid & ~abort;
  assign count_inc_s    = count_r + CNT_ONE;

  misr_reg #(
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr_reg (
    .clk  (clk),
    .rst  (rst),
    .load (accept_start_s),
    .en   (transfer_s),
    .data (resp.resp_data),
    .sig  (sig_s)
  );

  // Campaign FSM with pattern counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      count_r  <= CNT_ZERO;
      target_r <= CNT_ZERO;
      golden_r <= {SIG_W_DEF{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
    end else if (abort) begin
      state_r  <= ST_IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            count_r  <= CNT_ZERO;
            target_r <= num_patterns;
            golden_r <= golden_sig;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
            // An empty campaign goes straight to the compare.
            state_r  <= (num_patterns == CNT_ZERO) ? ST_CHECK : ST_RUN;
          end else begin
            state_r  <= state_r;
          end
        end
        ST_RUN: begin
          if (transfer_s) begin
            count_r <= count_inc_s;
            // count stops exactly at the target, so it cannot wrap
            // even for an all-ones campaign length.
            if (count_inc_s == target_r) begin
              state_r <= ST_CHECK;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_CHECK: begin
          pass_r  <= (sig_s == golden_r);
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_DONE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          pass_r  <= 1'b0;
        end
      endcase
    end
  end

  assign resp.resp_ready = (state_r == ST_RUN);
  assign busy            = busy_r;
  assign done            = done_r;
  assign pass            = pass_r;
  assign signature       = sig_s;
  assign pattern_count   = count_r;

endmodule

// File: doc/misr_response_checker.md
Name: misr_response_checker

Overview:
- Sequential capture stage directly downstream of the c880 circuit-under-test (CUT). It consumes the CUT's 26-bit primary-output vector (N388..N880, packed in declaration order) once per applied pattern.
- Compacts the responses with a multiple-input signature register (MISR), counts the accepted patterns and compares the final signature against a golden (Trojan-free) signature.
- Produces a pass/fail verdict per pattern campaign for the evolutionary Trojan-detection flow.

Parameters:
- RESP_W, 26, width of the CUT response vector.
- SIG_W, 32, MISR width; must be >= RESP_W.
- CNT_W, 16, pattern-counter width.
- POLY, 32'h04C11DB7, MISR feedback polynomial (taps XORed in when the shifted-out MSB is 1).
- SEED, 32'h00000000, MISR value loaded at campaign start.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a campaign (honoured only in IDLE or DONE)
- abort  in  1  returns the FSM to IDLE from any state; signature is left unchanged
- num_patterns  in  CNT_W  number of responses in the campaign; sampled on start
- golden_sig  in  SIG_W  expected signature; sampled on start
- resp_valid  in  1  CUT response valid
- resp_data  in  RESP_W  CUT response: bit0=N388 ... bit25=N880
- resp_ready  out  1  checker accepts a response this cycle
- busy  out  1  high in RUN and CHECK
- done  out  1  high in DONE
- pass  out  1  signature == golden; meaningful only while done=1
- signature  out  SIG_W  current MISR value
- pattern_count  out  CNT_W  number of responses accepted in this campaign

Behaviour:
- Reset: state=IDLE; signature=SEED; pattern_count=0; resp_ready=0; busy=0; done=0; pass=0.
- FSM states: IDLE, RUN, CHECK, DONE. Transitions:
  - IDLE or DONE, start=1: load signature=SEED, pattern_count=0, latch num_patterns and golden_sig, clear done and pass. Next state is RUN, or CHECK if num_patterns==0.
  - RUN: resp_ready=1 (driven combinationally from state). A transfer occurs when resp_valid & resp_ready.
    - On a transfer: sig' = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_extend(resp_data); pattern_count increments.
    - When the transfer makes pattern_count equal to the latched num_patterns, the next state is CHECK.
    - No update on cycles without a transfer. resp_valid gaps of any length are allowed.
  - CHECK: one cycle. pass <= (signature == latched golden). Next state is DONE. resp_ready=0.
  - DONE: done=1; pass, signature and pattern_count hold until the next start.
- Latency: the verdict is visible 2 cycles after the final transfer edge (one cycle into CHECK, then DONE).
- start while busy: ignored.
- abort has priority over start and over a transfer in the same cycle: next state is IDLE, done=0, pass=0.
- rst mid-campaign: full reset values apply; any partial signature is discarded.
- pattern_count never wraps: in RUN it stops at num_patterns. A num_patterns of 2^CNT_W-1 is legal.
- resp_data changes while resp_valid=0 have no effect.

Decomposition:
- Shared package misr_pkg holds:
  - default POLY and SEED constants;
  - the state enum (IDLE, RUN, CHECK, DONE);
  - a function misr_next(sig, data) implementing the update equation. The campaign TB model reuses the same function.
- One sub-module, misr_reg: SIG_W register with load (SEED), enable (transfer) and data inputs. The checker top instantiates it and contains the FSM and counter.

Test Plan:
- Reset then idle: after rst, signature=0, pattern_count=0, done=0, resp_ready=0; resp_valid=1 for 5 cycles -> no change.
- Basic compaction: SEED=0, start with num_patterns=2, golden=32'h00000003, two transfers of 26'h0000001 -> after the 1st signature=1, after the 2nd =3; done=1 and pass=1 two cycles after the 2nd transfer.
- Feedback path: SEED=32'h80000000, num_patterns=1, resp=0 -> signature=32'h04C11DB7. With golden=32'h04C11DB6 -> done=1, pass=0.
- Zero-length campaign: num_patterns=0, golden=SEED -> resp_ready never asserts; done=1 and pass=1 on cycle 2 after start.
- Backpressure and gaps: num_patterns=3 with resp_valid toggling 1,0,0,1,0,1 -> exactly 3 transfers, signature matches misr_next applied 3 times; a 4th valid cycle after that is not accepted (resp_ready=0).
- Abort and reset mid-run: after 1 of 4 transfers, assert abort together with resp_valid -> state IDLE, pattern_count stays 1, done=0. Restart, then assert rst after 2 transfers -> all outputs return to reset values.
